fta_bridge_wide2narrow: RTL and testbench

//  Sequential FTA width-down bridge: one wide request becomes one narrow beat per

---
 rtl/fta_bridge_wide2narrow.sv | 190 +++++++++++++++++++
 tb/tb_fta_bridge_wide2narrow.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fta_bridge_wide2narrow.sv
// ---------------------------------------------------------------------------
// fta_bridge_wide2narrow
// Sequential FTA width-down bridge. One wide request is split into one narrow
// beat per active narrow lane (ascending lane order); the in-order narrow
// responses are merged back into a single wide response.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   wreq_*               wide request (cyc/we/adr/sel/dat/tid), wreq_stall_o busy
//   wresp_*              wide response (ack pulse, err, tid, adr, merged dat)
//   nreq_*               narrow beat (cyc/we/adr/sel/dat/tid), nreq_stall_i backpressure
//   nresp_*              narrow response (ack, err, dat)
//
// state  | meaning
// -------+-------------------------------------------------------------------
// IDLE   | no transaction; a wide request is captured when offered
// ISSUE  | issuing narrow beats for the remaining lanes of the issue mask
// WAIT   | all beats accepted, collecting the outstanding narrow responses
// RESP   | one-cycle wide response; a new request may be captured here
// ---------------------------------------------------------------------------
module fta_bridge_wide2narrow #(
   parameter int WIDE_W   = 256,
   parameter int NARROW_W = 64,
   parameter int ADR_W    = 32,
   parameter int TID_W    = 13,
   parameter int TIMEOUT  = 255
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  wreq_cyc_i,
   input  logic                  wreq_we_i,
   input  logic [ADR_W-1:0]      wreq_adr_i,
   input  logic [WIDE_W/8-1:0]   wreq_sel_i,
   input  logic [WIDE_W-1:0]     wreq_dat_i,
   input  logic [TID_W-1:0]      wreq_tid_i,
   output logic                  wreq_stall_o,
   output logic                  wresp_ack_o,
   output logic                  wresp_err_o,
   output logic [TID_W-1:0]      wresp_tid_o,
   output logic [ADR_W-1:0]      wresp_adr_o,
   output logic [WIDE_W-1:0]     wresp_dat_o,
   output logic                  nreq_cyc_o,
   output logic                  nreq_we_o,
   output logic [ADR_W-1:0]      nreq_adr_o,
   output logic [NARROW_W/8-1:0] nreq_sel_o,
   output logic [NARROW_W-1:0]   nreq_dat_o,
   output logic [TID_W-1:0]      nreq_tid_o,
   input  logic                  nreq_stall_i,
   input  logic                  nresp_ack_i,
   input  logic                  nresp_err_i,
   input  logic [NARROW_W-1:0]   nresp_dat_i
);

   localparam int L   = WIDE_W / NARROW_W;
   localparam int NB  = NARROW_W / 8;
   localparam int WSB = $clog2(WIDE_W / 8);
   localparam int NSB = $clog2(NB);
   localparam int KW  = (L > 1) ? $clog2(L) : 1;
   localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] T_LOAD = TW'(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [ADR_W-1:0]      adr_q;
   logic [WIDE_W/8-1:0]   sel_q;
   logic [WIDE_W-1:0]     dat_q;
   logic [TID_W-1:0]      tid_q;
   logic                  we_q;
   logic [L-1:0]          issue_q, pend_q;
   logic [WIDE_W-1:0]     rdat_q;
   logic                  err_q;
   logic [TW-1:0]         timer_q;

   logic [L-1:0]          lane_act, issue_clr, pend_clr;
   logic [KW-1:0]         k_issue, k_pend;
   logic                  capture, busy, accept, ack_hit, tmo_hit;
   logic [ADR_W-1:0]      adr_base;

   // lane activity of the offered request, and lowest-set-lane encoders
   always_comb begin
      lane_act = '0;
      k_issue  = '0;
      k_pend   = '0;
      for (int i = 0; i < L; i++) begin
         lane_act[i] = |wreq_sel_i[i*NB +: NB];
      end
      for (int i = L - 1; i >= 0; i--) begin
         if (issue_q[i]) k_issue = KW'(i);
         if (pend_q[i])  k_pend  = KW'(i);
      end
   end

   assign busy       = (state_q == S_ISSUE) || (state_q == S_WAIT);
   assign capture    = wreq_cyc_i && ((state_q == S_IDLE) || (state_q == S_RESP));
   assign nreq_cyc_o = (state_q == S_ISSUE) && (|issue_q);
   assign accept     = nreq_cyc_o && !nreq_stall_i;
   // acks with nothing pending (stray, or after a timeout) are dropped
   assign ack_hit    = busy && nresp_ack_i && (|pend_q);
   assign issue_clr  = accept  ? (L'(1) << k_issue) : '0;
   assign pend_clr   = ack_hit ? (L'(1) << k_pend)  : '0;
   // timer holds 1 on the last idle cycle before expiry; any traffic reloads it
   assign tmo_hit    = (TIMEOUT != 0) && busy && !accept && !ack_hit && (timer_q == TW'(1));

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_RESP: begin
            if (wreq_cyc_i) state_d = (|wreq_sel_i) ? S_ISSUE : S_RESP;
            else            state_d = S_IDLE;
         end
         S_ISSUE: begin
            if (tmo_hit)                                    state_d = S_RESP;
            else if (accept && ((issue_q & ~issue_clr) == '0)) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (tmo_hit || ((pend_q & ~pend_clr) == '0)) state_d = S_RESP;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         adr_q   <= '0;
         sel_q   <= '0;
         dat_q   <= '0;
         tid_q   <= '0;
         we_q    <= 1'b0;
         issue_q <= '0;
         pend_q  <= '0;
         rdat_q  <= '0;
         err_q   <= 1'b0;
         timer_q <= '0;
      end else if (capture) begin
         adr_q   <= wreq_adr_i;
         sel_q   <= wreq_sel_i;
         dat_q   <= wreq_dat_i;
         tid_q   <= wreq_tid_i;
         we_q    <= wreq_we_i;
         issue_q <= lane_act;
         pend_q  <= lane_act;
         rdat_q  <= '0;
         err_q   <= ~|wreq_sel_i;
         timer_q <= T_LOAD;
      end else if (busy) begin
         if (tmo_hit) begin
            err_q   <= 1'b1;
            issue_q <= '0;
            pend_q  <= '0;
         end else begin
            issue_q <= issue_q & ~issue_clr;
            pend_q  <= pend_q & ~pend_clr;
            if (ack_hit) begin
               rdat_q[int'(k_pend)*NARROW_W +: NARROW_W] <= we_q ? '0 : nresp_dat_i;
               err_q <= err_q | nresp_err_i;
            end
            if (accept || ack_hit)   timer_q <= T_LOAD;
            else if (timer_q != '0)  timer_q <= timer_q - 1'b1;
         end
      end
   end

   assign adr_base = {adr_q[ADR_W-1:WSB], {WSB{1'b0}}};

   assign nreq_we_o  = nreq_cyc_o && we_q;
   assign nreq_adr_o = nreq_cyc_o ? (adr_base | (ADR_W'(k_issue) << NSB)) : '0;
   assign nreq_sel_o = nreq_cyc_o ? sel_q[int'(k_issue)*NB +: NB] : '0;
   assign nreq_dat_o = nreq_cyc_o ? dat_q[int'(k_issue)*NARROW_W +: NARROW_W] : '0;
   assign nreq_tid_o = nreq_cyc_o ? tid_q : '0;

   // stall is low whenever a request can be captured, including the response cycle
   assign wreq_stall_o = busy;
   assign wresp_ack_o  = (state_q == S_RESP);
   assign wresp_err_o  = wresp_ack_o && err_q;
   assign wresp_tid_o  = wresp_ack_o ? tid_q  : '0;
   assign wresp_adr_o  = wresp_ack_o ? adr_q  : '0;
   assign wresp_dat_o  = wresp_ack_o ? rdat_q : '0;

endmodule

// File: tb/tb_fta_bridge_wide2narrow.sv
module tb_fta_bridge_wide2narrow;

   typedef struct {
      logic [12:0]  tid;
      logic [31:0]  adr;
      logic         err;
      logic [255:0] dat;
   } exp_t;

   typedef struct {
      logic [31:0] adr;
      logic [7:0]  sel;
      logic [63:0] dat;
      logic        we;
      logic [12:0] tid;
   } beat_t;

   typedef struct {
      logic [63:0] dat;
      logic        err;
      int          due;
   } rsp_t;

   logic         clk = 1'b0;
   logic         rst_ni;
   logic         wreq_cyc_i, wreq_we_i;
   logic [31:0]  wreq_adr_i;
   logic [31:0]  wreq_sel_i;
   logic [255:0] wreq_dat_i;
   logic [12:0]  wreq_tid_i;
   logic         wreq_stall_o, wresp_ack_o, wresp_err_o;
   logic [12:0]  wresp_tid_o;
   logic [31:0]  wresp_adr_o;
   logic [255:0] wresp_dat_o;
   logic         nreq_cyc_o, nreq_we_o;
   logic [31:0]  nreq_adr_o;
   logic [7:0]   nreq_sel_o;
   logic [63:0]  nreq_dat_o;
   logic [12:0]  nreq_tid_o;
   logic         nreq_stall_i, nresp_ack_i, nresp_err_i;
   logic [63:0]  nresp_dat_i;

   fta_bridge_wide2narrow #(
      .WIDE_W(256), .NARROW_W(64), .ADR_W(32), .TID_W(13), .TIMEOUT(8)
   ) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .wreq_cyc_i(wreq_cyc_i), .wreq_we_i(wreq_we_i), .wreq_adr_i(wreq_adr_i),
      .wreq_sel_i(wreq_sel_i), .wreq_dat_i(wreq_dat_i), .wreq_tid_i(wreq_tid_i),
      .wreq_stall_o(wreq_stall_o),
      .wresp_ack_o(wresp_ack_o), .wresp_err_o(wresp_err_o), .wresp_tid_o(wresp_tid_o),
      .wresp_adr_o(wresp_adr_o), .wresp_dat_o(wresp_dat_o),
      .nreq_cyc_o(nreq_cyc_o), .nreq_we_o(nreq_we_o), .nreq_adr_o(nreq_adr_o),
      .nreq_sel_o(nreq_sel_o), .nreq_dat_o(nreq_dat_o), .nreq_tid_o(nreq_tid_o),
      .nreq_stall_i(nreq_stall_i),
      .nresp_ack_i(nresp_ack_i), .nresp_err_i(nresp_err_i), .nresp_dat_i(nresp_dat_i)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   exp_t  exp_q[$];
   beat_t beat_q[$];
   rsp_t  resp_q[$];

   logic [63:0] rd_base      = 64'hA5A5_A5A5_A5A5_A5A5;
   logic [3:0]  err_lanes    = 4'b0;
   logic        slave_mute   = 1'b0;
   logic        stray_req    = 1'b0;
   int          stall_cycles = 0;
   int          ack_lat      = 0;
   int          stall_cnt    = 0;
   int          beats_seen   = 0;
   int          n_resp       = 0;
   int          cap_cyc      = 0;
   int          ack_cyc      = 0;
   int          last_acc     = 0;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // narrow slave: checks each accepted beat, returns in-order responses
   initial begin : slave
      beat_t b;
      rsp_t  r;
      nreq_stall_i = 1'b0;
      nresp_ack_i  = 1'b0;
      nresp_err_i  = 1'b0;
      nresp_dat_i  = '0;
      forever begin
         @(negedge clk);
         if (!rst_ni) begin
            nreq_stall_i = 1'b0;
            nresp_ack_i  = 1'b0;
            nresp_err_i  = 1'b0;
            nresp_dat_i  = '0;
            stall_cnt    = 0;
            resp_q.delete();
            continue;
         end
         if (nreq_cyc_o && stall_cnt < stall_cycles) begin
            nreq_stall_i = 1'b1;
            stall_cnt++;
         end else begin
            nreq_stall_i = 1'b0;
         end
         if (nreq_cyc_o && !nreq_stall_i) begin
            stall_cnt = 0;
            beats_seen++;
            last_acc = cyc_cnt + 1;
            if (beat_q.size() == 0) begin
               chk("unexp_beat", 1, 0);
            end else begin
               b = beat_q.pop_front();
               chk("beat_adr", nreq_adr_o, b.adr);
               chk("beat_sel", nreq_sel_o, b.sel);
               chk("beat_dat", nreq_dat_o, b.dat);
               chk("beat_we",  nreq_we_o,  b.we);
               chk("beat_tid", nreq_tid_o, b.tid);
            end
            if (!slave_mute) begin
               r.dat = rd_base ^ {56'h0, nreq_adr_o[7:0]};
               r.err = err_lanes[nreq_adr_o[4:3]];
               r.due = cyc_cnt + 1 + ack_lat;
               resp_q.push_back(r);
            end
         end
         nresp_ack_i = 1'b0;
         nresp_err_i = 1'b0;
         nresp_dat_i = '0;
         if (stray_req) begin
            nresp_ack_i = 1'b1;
            nresp_err_i = 1'b1;
            nresp_dat_i = 64'hDEAD_BEEF_DEAD_BEEF;
            stray_req   = 1'b0;
         end else if (resp_q.size() != 0 && resp_q[0].due <= cyc_cnt + 1) begin
            r = resp_q.pop_front();
            nresp_ack_i = 1'b1;
            nresp_err_i = r.err;
            nresp_dat_i = r.dat;
         end
      end
   end

   // wide response monitor
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_ni && wresp_ack_o) begin
            ack_cyc = cyc_cnt;
            if (exp_q.size() == 0) begin
               chk("unexp_ack", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("resp_tid", wresp_tid_o, e.tid);
               chk("resp_adr", wresp_adr_o, e.adr);
               chk("resp_err", wresp_err_o, e.err);
               chk("resp_dat", wresp_dat_o, e.dat);
            end
            n_resp++;
         end
      end
   end

   task automatic send(input logic we, input logic [31:0] adr, input logic [31:0] sel,
                       input logic [255:0] dat, input logic [12:0] tid);
      exp_t  e;
      beat_t b;
      int    g;
      @(negedge clk);
      wreq_cyc_i = 1'b1;
      wreq_we_i  = we;
      wreq_adr_i = adr;
      wreq_sel_i = sel;
      wreq_dat_i = dat;
      wreq_tid_i = tid;
      g = 0;
      while (wreq_stall_o && g < 100) begin
         @(negedge clk);
         g++;
      end
      if (wreq_stall_o) chk("req_stall_bound", 1, 0);
      cap_cyc = cyc_cnt + 1;
      e.tid = tid;
      e.adr = adr;
      e.err = (sel == 32'h0) || slave_mute;
      e.dat = '0;
      for (int i = 0; i < 4; i++) begin
         if (|sel[i*8 +: 8]) begin
            b.adr = {adr[31:5], 5'b0} + 32'(i * 8);
            b.sel = sel[i*8 +: 8];
            b.dat = dat[i*64 +: 64];
            b.we  = we;
            b.tid = tid;
            beat_q.push_back(b);
            if (err_lanes[i]) e.err = 1'b1;
            if (!we && !slave_mute) e.dat[i*64 +: 64] = rd_base ^ {56'h0, b.adr[7:0]};
         end
      end
      exp_q.push_back(e);
      @(negedge clk);
      wreq_cyc_i = 1'b0;
   endtask

   task automatic wait_resp(input int r0);
      int g = 0;
      while (n_resp == r0 && g < 100) begin
         @(negedge clk);
         #1;
         g++;
      end
      if (n_resp == r0) chk("resp_bound", 0, 1);
   endtask

   task automatic wait_idle();
      int g = 0;
      while ((exp_q.size() != 0 || beat_q.size() != 0 || resp_q.size() != 0) && g < 300) begin
         @(negedge clk);
         #1;
         g++;
      end
      chk("idle_bound", exp_q.size() + beat_q.size() + resp_q.size(), 0);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int r0, b0;
      logic [255:0] wd;
      rst_ni     = 1'b0;
      wreq_cyc_i = 1'b0;
      wreq_we_i  = 1'b0;
      wreq_adr_i = '0;
      wreq_sel_i = '0;
      wreq_dat_i = '0;
      wreq_tid_i = '0;
      repeat (3) @(negedge clk);
      chk("rst_stall", wreq_stall_o, 0);
      chk("rst_ack",   wresp_ack_o, 0);
      chk("rst_cyc",   nreq_cyc_o, 0);
      chk("rst_dat",   wresp_dat_o, 0);
      chk("rst_nadr",  nreq_adr_o, 0);
      rst_ni = 1'b1;

      // 1: single-lane read, minimum latency
      r0 = n_resp; b0 = beats_seen;
      send(1'b0, 32'h1000, 32'h0000_00FF, '0, 13'h11);
      wait_resp(r0);
      chk("t1_latency", ack_cyc - cap_cyc, 2);
      chk("t1_beats", beats_seen - b0, 1);
      wait_idle();

      // 2: two-lane write
      r0 = n_resp; b0 = beats_seen;
      wd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      send(1'b1, 32'h2000, 32'hFF00_00F0, wd, 13'd5);
      wait_resp(r0);
      chk("t2_beats", beats_seen - b0, 2);
      wait_idle();

      // 3: all lanes with 3 stall cycles per beat, delayed acks
      stall_cycles = 3; ack_lat = 1;
      r0 = n_resp; b0 = beats_seen;
      send(1'b0, 32'h3040, 32'hFFFF_FFFF, '0, 13'h33);
      wait_resp(r0);
      chk("t3_beats", beats_seen - b0, 4);
      wait_idle();
      stall_cycles = 0; ack_lat = 0;

      // 4: error on the second lane of a two-lane read
      err_lanes = 4'b0010; rd_base = 64'h0123_4567_89AB_CDEF;
      r0 = n_resp;
      send(1'b0, 32'h5000, 32'h0000_FFFF, '0, 13'h44);
      wait_resp(r0);
      wait_idle();
      err_lanes = 4'b0;

      // 5: no narrow ack -> timeout 8 cycles after the accept
      slave_mute = 1'b1;
      r0 = n_resp;
      send(1'b0, 32'h4000, 32'h0000_FF00, '0, 13'h55);
      wait_resp(r0);
      chk("t5_tmo_latency", ack_cyc - last_acc, 8);
      wait_idle();
      slave_mute = 1'b0;
      stray_req  = 1'b1;
      repeat (2) @(negedge clk);
      r0 = n_resp;
      send(1'b0, 32'h4100, 32'hFF00_0000, '0, 13'h56);
      wait_resp(r0);
      wait_idle();

      // 6a: empty sel
      r0 = n_resp; b0 = beats_seen;
      send(1'b0, 32'h6000, 32'h0, '0, 13'h66);
      wait_resp(r0);
      chk("t6_sel0_latency", ack_cyc - cap_cyc, 0);
      chk("t6_sel0_beats", beats_seen - b0, 0);
      wait_idle();

      // 6b: reset while waiting for a narrow response
      slave_mute = 1'b1;
      send(1'b0, 32'h7000, 32'h0000_00FF, '0, 13'h77);
      repeat (2) @(negedge clk);
      #1;
      chk("t6_wait_stall", wreq_stall_o, 1);
      #1 rst_ni = 1'b0;
      #1;
      chk("t6_rst_stall", wreq_stall_o, 0);
      chk("t6_rst_ack",   wresp_ack_o, 0);
      chk("t6_rst_cyc",   nreq_cyc_o, 0);
      exp_q.delete(); beat_q.delete();
      repeat (2) @(negedge clk);
      rst_ni = 1'b1; slave_mute = 1'b0;
      r0 = n_resp;
      repeat (12) @(negedge clk);
      #1;
      chk("t6_no_resp", n_resp - r0, 0);

      // 6c: reset while a beat is stalled drops nreq_cyc_o immediately
      stall_cycles = 100;
      send(1'b0, 32'h7100, 32'h00FF_0000, '0, 13'h78);
      #1;
      chk("t6_issue_cyc", nreq_cyc_o, 1);
      #1 rst_ni = 1'b0;
      #1;
      chk("t6_async_cyc", nreq_cyc_o, 0);
      exp_q.delete(); beat_q.delete();
      repeat (2) @(negedge clk);
      rst_ni = 1'b1; stall_cycles = 0;
      repeat (2) @(negedge clk);

      // mixed traffic, back-to-back pairs
      for (int it = 0; it < 10; it++) begin
         ack_lat      = $urandom_range(0, 3);
         stall_cycles = $urandom_range(0, 2);
         rd_base      = {$urandom, $urandom};
         for (int j = 0; j < 2; j++) begin
            wd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            send(1'($urandom_range(0, 1)), $urandom, $urandom & $urandom, wd, 13'($urandom));
         end
         wait_idle();
      end

      repeat (4) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
